// File: rtl/pipe_register.sv
// Elastic valid/ready pipeline register, STAGES deep, with a synchronous flush; skid slot enabled by PIPE_REGISTER_SKID_EN.
// Latency: a word accepted at edge n is on o_data after edge n+STAGES-1; one word per cycle at full rate.
// Backpressure: bubbles collapse; o_ready is combinational from i_ready, or registered (~skid occupied) with the skid slot.
module pipe_register #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATA_WIDTH-1:0]       i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [$clog2(STAGES+2)-1:0] o_level
);

  localparam int LW = $clog2(STAGES + 2);
`ifdef PIPE_REGISTER_SKID_EN
  localparam int CAP = STAGES + 1;
`else
  localparam int CAP = STAGES;
`endif

  logic [STAGES-1:0]     stg_vld;
  logic [DATA_WIDTH-1:0] stg_dat [STAGES];
  logic [STAGES-1:0]     stg_rdy;
  logic                  src_vld;
  logic [DATA_WIDTH-1:0] src_dat;
  logic                  push;
  logic                  pop;
  logic [LW-1:0]         level_q;

  // A stage is ready unless it and every stage after it are occupied while the sink stalls.
  always_comb begin : ready_chain
    logic tail_full;
    tail_full = 1'b1;
    stg_rdy   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      tail_full  = tail_full & stg_vld[k];
      stg_rdy[k] = ~tail_full | i_ready;
    end
  end

`ifdef PIPE_REGISTER_SKID_EN
  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] skid_dat;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (skid_vld) begin
      if (stg_rdy[0]) skid_vld <= 1'b0;
    end else if (i_valid && !stg_rdy[0]) begin
      skid_vld <= 1'b1;
      skid_dat <= i_data;
    end
  end

  // While the skid slot is occupied no new word is accepted, so it alone feeds stage 0.
  assign o_ready = ~skid_vld;
  assign src_vld = skid_vld | i_valid;
  assign src_dat = skid_vld ? skid_dat : i_data;
`else
  assign o_ready = stg_rdy[0];
  assign src_vld = i_valid;
  assign src_dat = i_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      stg_vld <= '0;
      for (int k = 0; k < STAGES; k++) stg_dat[k] <= '0;
    end else begin
      if (stg_rdy[0]) begin
        stg_vld[0] <= src_vld;
        if (src_vld) stg_dat[0] <= src_dat;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stg_rdy[k]) begin
          stg_vld[k] <= stg_vld[k-1];
          if (stg_vld[k-1]) stg_dat[k] <= stg_dat[k-1];
        end
      end
    end
  end

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + LW'(1);
    end else if (pop && !push) begin
      level_q <= level_q - LW'(1);
    end
    if (!i_rst) assert (level_q <= LW'(CAP));
  end

  assign o_valid = stg_vld[STAGES-1];
  assign o_data  = stg_dat[STAGES-1];
  assign o_level = level_q;

endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: directed literal checks plus randomized traffic against a queue model.
module tb_pipe_register;
  localparam int DW = 8;
  localparam int S  = 2;
  localparam int LW = $clog2(S + 2);
`ifdef PIPE_REGISTER_SKID_EN
  localparam int  CAP  = S + 1;
  localparam bit  SKID = 1'b1;
`else
  localparam int  CAP  = S;
  localparam bit  SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst, i_clr, i_valid, i_ready;
  logic          o_ready, o_valid;
  logic [DW-1:0] i_data, o_data;
  logic [LW-1:0] o_level;

  pipe_register #(.DATA_WIDTH(DW), .STAGES(S)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clr(i_clr),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_level(o_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edges = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) edges++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: ordered queue of stored words with their acceptance edge.
  // The oldest word reaches the output STAGES-1 edges after acceptance.
  logic [DW-1:0] mq_d[$];
  int            mq_t[$];
  bit            ev, er, m_push, m_pop;

  always @(negedge clk) begin
    ev = 1'b0;
    if (mq_d.size() > 0) ev = (edges - mq_t[0]) >= (S - 1);
    if (SKID) er = (mq_d.size() != CAP);
    else      er = (mq_d.size() < CAP) || (i_ready === 1'b1);
    if (chk_en) begin
      check("m_valid", {31'b0, o_valid}, {31'b0, ev});
      if (ev) check("m_data", {24'b0, o_data}, {24'b0, mq_d[0]});
      check("m_level", {{(32-LW){1'b0}}, o_level}, mq_d.size());
      check("m_ready", {31'b0, o_ready}, {31'b0, er});
    end
    if (i_rst || i_clr) begin
      mq_d.delete();
      mq_t.delete();
    end else begin
      m_pop  = ev && i_ready;
      m_push = i_valid && er;
      if (m_pop) begin
        void'(mq_d.pop_front());
        void'(mq_t.pop_front());
      end
      if (m_push) begin
        mq_d.push_back(i_data);
        mq_t.push_back(edges + 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pending;
    int vbias, rbias;

    // Reset with junk on the inputs
    i_rst = 1'b1; i_clr = 1'b0; i_valid = 1'b1; i_data = 8'hFF; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_data", {24'b0, o_data}, 32'd0);
    check("rst_level", {{(32-LW){1'b0}}, o_level}, 32'd0);
    i_rst = 1'b0; i_valid = 1'b0; i_data = '0;
    #1;
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    chk_en = 1'b1;

    // Streaming 01..10 back-to-back
    for (int i = 1; i <= 18; i++) begin
      i_valid = (i <= 16); i_data = 8'(i); i_ready = 1'b1;
      @(negedge clk);
      check("stream_ready", {31'b0, o_ready}, 32'd1);
      if (i >= 3) begin
        check("stream_valid", {31'b0, o_valid}, 32'd1);
        check("stream_data", {24'b0, o_data}, 32'(i - 2));
      end
      step();
    end
    i_valid = 1'b0;
    step();

    // Backpressure
    i_ready = 1'b0; i_valid = 1'b1; i_data = 8'hA0; step();
    i_data = 8'hA1; step();
    i_data = 8'hA2;
`ifdef PIPE_REGISTER_SKID_EN
    @(negedge clk);
    check("bp_ready", {31'b0, o_ready}, 32'd1);
    check("bp_level", {{(32-LW){1'b0}}, o_level}, 32'd2);
    step();
    i_valid = 1'b0;
    @(negedge clk);
    check("bp_skid_ready", {31'b0, o_ready}, 32'd0);
    check("bp_skid_level", {{(32-LW){1'b0}}, o_level}, 32'd3);
    check("bp_data0", {24'b0, o_data}, 32'hA0);
    step();
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_data0", {24'b0, o_data}, 32'hA0);
    check("bp_skid_ready", {31'b0, o_ready}, 32'd0);
    step();
`else
    repeat (2) begin
      @(negedge clk);
      check("bp_ready", {31'b0, o_ready}, 32'd0);
      check("bp_level", {{(32-LW){1'b0}}, o_level}, 32'd2);
      check("bp_data0", {24'b0, o_data}, 32'hA0);
      step();
    end
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_data0", {24'b0, o_data}, 32'hA0);
    check("bp_ready", {31'b0, o_ready}, 32'd1);
    step();
    i_valid = 1'b0;
`endif
    @(negedge clk);
    check("bp_data1", {24'b0, o_data}, 32'hA1);
    check("bp_level", {{(32-LW){1'b0}}, o_level}, 32'd2);
    check("bp_ready_after", {31'b0, o_ready}, 32'd1);
    step();
    @(negedge clk);
    check("bp_data2", {24'b0, o_data}, 32'hA2);
    check("bp_level", {{(32-LW){1'b0}}, o_level}, 32'd1);
    step();
    @(negedge clk);
    check("bp_empty", {31'b0, o_valid}, 32'd0);
    step();

    // Simultaneous push/pop while full
    i_ready = 1'b0; i_valid = 1'b1; i_data = 8'hB0; step();
    i_data = 8'hB1; step();
    for (int j = 0; j < 10; j++) begin
      i_ready = 1'b1; i_data = 8'(8'hB2 + j);
      @(negedge clk);
      check("full_level", {{(32-LW){1'b0}}, o_level}, 32'd2);
      check("full_data", {24'b0, o_data}, 32'(8'hB0 + j));
      check("full_ready", {31'b0, o_ready}, 32'd1);
      step();
    end
    i_valid = 1'b0;
    repeat (3) step();

    // Clear mid-stream
    i_ready = 1'b0; i_valid = 1'b1; i_data = 8'h11; step();
    i_data = 8'h22; step();
    i_clr = 1'b1; i_data = 8'h33; step();
    i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    check("clr_valid", {31'b0, o_valid}, 32'd0);
    check("clr_level", {{(32-LW){1'b0}}, o_level}, 32'd0);
    check("clr_data", {24'b0, o_data}, 32'd0);
    step();
    i_valid = 1'b1; i_data = 8'h44; step();
    i_valid = 1'b0;
    @(negedge clk);
    check("clr_lat_valid", {31'b0, o_valid}, 32'd0);
    step();
    @(negedge clk);
    check("clr_lat_valid", {31'b0, o_valid}, 32'd1);
    check("clr_lat_data", {24'b0, o_data}, 32'h44);
    step();

`ifdef PIPE_REGISTER_SKID_EN
    // Skid slot catches a word pushed into a full, stalled pipe
    i_ready = 1'b0; i_valid = 1'b1; i_data = 8'h50; step();
    i_data = 8'h51; step();
    i_data = 8'h55; step();
    i_valid = 1'b0;
    @(negedge clk);
    check("skid_ready", {31'b0, o_ready}, 32'd0);
    check("skid_level", {{(32-LW){1'b0}}, o_level}, 32'd3);
    step();
    i_ready = 1'b1;
    @(negedge clk);
    check("skid_data0", {24'b0, o_data}, 32'h50);
    step();
    @(negedge clk);
    check("skid_data1", {24'b0, o_data}, 32'h51);
    check("skid_ready_rise", {31'b0, o_ready}, 32'd1);
    step();
    @(negedge clk);
    check("skid_data2", {24'b0, o_data}, 32'h55);
    step();
    step();
`endif

    // Randomized traffic; an unaccepted word is held until taken
    vbias = 70; rbias = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        vbias = $urandom_range(20, 100);
        rbias = $urandom_range(10, 100);
      end
      @(negedge clk);
      pending = i_valid && !o_ready && !i_clr && !i_rst;
      @(posedge clk);
      #1;
      i_rst = ($urandom_range(0, 299) == 0);
      i_clr = !i_rst && ($urandom_range(0, 59) == 0);
      if (!pending) begin
        i_valid = ($urandom_range(0, 99) < vbias);
        i_data  = 8'($urandom);
      end
      i_ready = ($urandom_range(0, 99) < rbias);
    end

    i_rst = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("final_empty", {31'b0, o_valid}, 32'd0);
    check("final_level", {{(32-LW){1'b0}}, o_level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
